// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// With SKID=1 the upstream ready is a decoded register (no path from out_ready) and the stage
// holds up to two entries. With SKID=0 it is a single-entry stage with combinational ready.
// A synchronous flush discards everything held.

module pipe_skid_reg #(
    parameter int unsigned N    = 32,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occ
);

    // The encoding equals the number of held entries, so occ comes straight off the state flops.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull1 = 2'd1,
        StFull2 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   main_q, main_d;
    logic [N-1:0]   skid_q, skid_d;
    logic           skid_valid;
    logic           accept;
    logic           retire;

    // Valids and ready decoded from registered state only.
    always_comb begin
        out_valid  = (state_q != StEmpty);
        skid_valid = (state_q == StFull2);
        if (SKID) begin
            in_ready = !skid_valid;
        end else begin
            in_ready = !out_valid || out_ready;
        end
        accept   = in_valid && in_ready;
        retire   = out_valid && out_ready;
        out_data = main_q;
        occ      = state_q;
    end

    // Next-state and datapath; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else if (SKID) begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StFull1;
                        main_d  = in_data;
                    end
                end
                StFull1: begin
                    if (accept && retire) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = StFull2;
                        skid_d  = in_data;
                    end else if (retire) begin
                        state_d = StEmpty;
                    end
                end
                StFull2: begin
                    // No accept possible here: in_ready is low while the skid is occupied.
                    if (retire) begin
                        state_d = StFull1;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end else begin
            // Single entry: an accept while full implies a retire in the same cycle.
            if (accept) begin
                state_d = StFull1;
                main_d  = in_data;
            end else if (retire) begin
                state_d = StEmpty;
            end
        end
    end

    // State and storage registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
